// File: rtl/matmul_sequencer_if.sv
// Memory port of the matrix-multiply sequencer: one combinational read port
// and one write port that commits on the clock edge.
interface matmul_sequencer_if #(
   parameter int SIZE = 8
);
   logic            mem_read;
   logic [31:0]     mem_raddr;
   logic [SIZE-1:0] mem_rdata;
   logic            mem_write;
   logic [31:0]     mem_waddr;
   logic [SIZE-1:0] mem_wdata;

   modport master (
      output mem_read, mem_raddr, mem_write, mem_waddr, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_read, mem_raddr, mem_write, mem_waddr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/matmul_sequencer.sv
// Computes C = A x B for N x N unsigned matrices held in a shared memory,
// one multiply-accumulate per read pair, writing C in row-major order.
module matmul_sequencer #(
   parameter int N    = 2,
   parameter int SIZE = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [31:0]         base_a,
   input  logic [31:0]         base_b,
   input  logic [31:0]         base_c,
   matmul_sequencer_if.master  mem,
   output logic                busy,
   output logic                done,
   output logic                overflow
);

   localparam int IW    = (N > 1) ? $clog2(N) : 1;
   localparam int ACC_W = 2 * SIZE + $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_t;

   state_t            state, state_nxt;
   logic [31:0]       ba_q, bb_q, bc_q;
   logic [IW-1:0]     i_q, j_q, k_q;
   logic [SIZE-1:0]   a_reg;
   logic [ACC_W-1:0]  acc;
   logic              ovf_q;
   logic              last_i, last_j, last_k;

   function automatic logic [31:0] elem_addr(input logic [31:0]   base,
                                              input logic [IW-1:0] row,
                                              input logic [IW-1:0] col);
      return base + 32'(row) * 32'(N) + 32'(col);
   endfunction

   // Accumulator is sized for N full-scale products, so this sum cannot wrap.
   function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0] sum,
                                             input logic [SIZE-1:0]  a,
                                             input logic [SIZE-1:0]  b);
      logic [2*SIZE-1:0] prod;
      prod = (2*SIZE)'(a) * (2*SIZE)'(b);
      return sum + ACC_W'(prod);
   endfunction

   function automatic logic exceeds_size(input logic [ACC_W-1:0] v);
      return |v[ACC_W-1:SIZE];
   endfunction

   assign last_i   = (i_q == LAST);
   assign last_j   = (j_q == LAST);
   assign last_k   = (k_q == LAST);
   assign overflow = ovf_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RD_A;
         RD_A:    state_nxt = abort ? IDLE : RD_B;
         RD_B: begin
            if (abort)       state_nxt = IDLE;
            else if (last_k) state_nxt = WR;
            else             state_nxt = RD_A;
         end
         WR: begin
            if (abort)                 state_nxt = IDLE;
            else if (last_i && last_j) state_nxt = DONE;
            else                       state_nxt = RD_A;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Abort gates the write combinationally so an aborted WR never commits.
   always_comb begin
      mem.mem_read  = 1'b0;
      mem.mem_raddr = '0;
      mem.mem_write = 1'b0;
      mem.mem_waddr = '0;
      mem.mem_wdata = '0;
      busy          = 1'b0;
      done          = 1'b0;
      unique case (state)
         RD_A: begin
            busy          = 1'b1;
            mem.mem_read  = 1'b1;
            mem.mem_raddr = elem_addr(ba_q, i_q, k_q);
         end
         RD_B: begin
            busy          = 1'b1;
            mem.mem_read  = 1'b1;
            mem.mem_raddr = elem_addr(bb_q, k_q, j_q);
         end
         WR: begin
            busy = 1'b1;
            if (!abort) begin
               mem.mem_write = 1'b1;
               mem.mem_waddr = elem_addr(bc_q, i_q, j_q);
               mem.mem_wdata = acc[SIZE-1:0];
            end
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ba_q  <= '0;
         bb_q  <= '0;
         bc_q  <= '0;
         i_q   <= '0;
         j_q   <= '0;
         k_q   <= '0;
         a_reg <= '0;
         acc   <= '0;
         ovf_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               ba_q  <= base_a;
               bb_q  <= base_b;
               bc_q  <= base_c;
               i_q   <= '0;
               j_q   <= '0;
               k_q   <= '0;
               acc   <= '0;
               ovf_q <= 1'b0;
            end
            RD_A: if (!abort) a_reg <= mem.mem_rdata;
            RD_B: if (!abort) begin
               acc <= mac(acc, a_reg, mem.mem_rdata);
               if (!last_k) k_q <= k_q + IW'(1);
            end
            WR: if (!abort) begin
               if (exceeds_size(acc)) ovf_q <= 1'b1;
               acc <= '0;
               k_q <= '0;
               if (last_j) begin
                  j_q <= '0;
                  i_q <= last_i ? '0 : i_q + IW'(1);
               end else begin
                  j_q <= j_q + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer (N=2, SIZE=8) with a small memory
// model and a queue of expected writes.
module tb_matmul_sequencer;

   typedef struct packed {
      logic [0:3][7:0] a;
      logic [0:3][7:0] b;
      logic [0:3][7:0] c;
      logic [31:0]     ba;
      logic [31:0]     bb;
      logic [31:0]     bc;
      logic            ovf;
   } vec_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [31:0] base_a, base_b, base_c;
   logic        busy, done, overflow;

   logic [7:0]  mem_arr [0:63];
   wr_t         exp_q [$];
   vec_t        vt [5];
   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;

   matmul_sequencer_if #(.SIZE(8)) mif ();

   matmul_sequencer #(.N(2), .SIZE(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .base_a   (base_a),
      .base_b   (base_b),
      .base_c   (base_c),
      .mem      (mif),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
   );

   assign mif.mem_rdata = mem_arr[mif.mem_raddr[5:0]];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Called at each falling edge: protocol rules, scoreboard, memory commit.
   task automatic mon();
      wr_t e;
      chk("proto_excl", 64'(mif.mem_read && mif.mem_write), 64'd0);
      if (!mif.mem_read) chk("proto_raddr0", 64'(mif.mem_raddr), 64'd0);
      if (!mif.mem_write) chk("proto_w0", {24'd0, mif.mem_waddr, mif.mem_wdata}, 64'd0);
      if (mif.mem_write) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {24'd0, mif.mem_waddr, mif.mem_wdata}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("write", {24'd0, mif.mem_waddr, mif.mem_wdata}, {24'd0, e.addr, e.data});
         end
         mem_arr[mif.mem_waddr[5:0]] = mif.mem_wdata;
      end
      if (done) done_cnt++;
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic load_vec(input vec_t v, input int nexp);
      logic [31:0] ad;
      for (int idx = 0; idx < 4; idx++) begin
         ad = v.ba + 32'(idx);
         mem_arr[ad[5:0]] = v.a[idx];
         ad = v.bb + 32'(idx);
         mem_arr[ad[5:0]] = v.b[idx];
         if (idx < nexp) exp_q.push_back('{addr: v.bc + 32'(idx), data: v.c[idx]});
      end
      base_a = v.ba;
      base_b = v.bb;
      base_c = v.bc;
   endtask

   // Full run from IDLE; optionally pulses start again in cycle poke_at.
   task automatic run_check(input string nm, input vec_t v, input int poke_at);
      int busy_n = 0;
      int done_at = 0;
      int d0 = done_cnt;
      load_vec(v, 4);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 40 && done_at == 0; c++) begin
         start = (c == poke_at);
         @(negedge clk);
         mon();
         if (busy) busy_n++;
         if (done) done_at = c;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk({nm, "_busy_cycles"}, 64'(busy_n), 64'd20);
      chk({nm, "_done_cycle"}, 64'(done_at), 64'd21);
      @(negedge clk);
      mon();
      chk({nm, "_after_done"}, {62'd0, busy, done}, 64'd0);
      @(posedge clk);
      #1;
      chk({nm, "_overflow"}, 64'(overflow), 64'(v.ovf));
      chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
      chk({nm, "_done_count"}, 64'(done_cnt - d0), 64'd1);
      exp_q.delete();
   endtask

   initial begin
      bit busyv [1:60];
      bit donev [1:60];
      int d0;

      vt[0] = '{a: {8'd200, 8'd200, 8'd200, 8'd200}, b: {8'd200, 8'd200, 8'd200, 8'd200},
                c: {8'd128, 8'd128, 8'd128, 8'd128}, ba: 32'd0, bb: 32'd4, bc: 32'd8, ovf: 1'b1};
      vt[1] = '{a: {8'd1, 8'd2, 8'd3, 8'd4}, b: {8'd5, 8'd6, 8'd7, 8'd8},
                c: {8'd19, 8'd22, 8'd43, 8'd50}, ba: 32'd0, bb: 32'd4, bc: 32'd8, ovf: 1'b0};
      vt[2] = '{a: {8'd16, 8'd1, 8'd2, 8'd3}, b: {8'd16, 8'd0, 8'd0, 8'd4},
                c: {8'd0, 8'd4, 8'd32, 8'd12}, ba: 32'd0, bb: 32'd4, bc: 32'd8, ovf: 1'b1};
      vt[3] = '{a: {8'd255, 8'd255, 8'd255, 8'd255}, b: {8'd1, 8'd0, 8'd0, 8'd1},
                c: {8'd255, 8'd255, 8'd255, 8'd255}, ba: 32'd0, bb: 32'd4, bc: 32'd8, ovf: 1'b0};
      vt[4] = '{a: {8'd1, 8'd0, 8'd0, 8'd1}, b: {8'd9, 8'd8, 8'd7, 8'd6},
                c: {8'd9, 8'd8, 8'd7, 8'd6}, ba: 32'd16, bb: 32'd20, bc: 32'hFFFF_FFFE, ovf: 1'b0};

      for (int m = 0; m < 64; m++) mem_arr[m] = 8'd0;
      rst = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      base_a = '0;
      base_b = '0;
      base_c = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_rw", {62'd0, mif.mem_read, mif.mem_write}, 64'd0);
      chk("rst_addr", {mif.mem_raddr, mif.mem_waddr}, 64'd0);
      chk("rst_wdata", 64'(mif.mem_wdata), 64'd0);
      rst = 1'b1;

      for (int v = 0; v < 5; v++) run_check($sformatf("vec%0d", v), vt[v], 0);

      run_check("start_busy", vt[1], 5);

      // Abort during the second write cycle (cycle 10).
      d0 = done_cnt;
      load_vec(vt[1], 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      abort = 1'b1;
      @(negedge clk);
      mon();
      chk("abort_no_write", 64'(mif.mem_write), 64'd0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      mon();
      chk("abort_busy_low", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      repeat (25) tick();
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      chk("abort_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      run_check("after_abort", vt[1], 0);

      // Asynchronous reset in cycle 7 after one overflowing write.
      d0 = done_cnt;
      load_vec(vt[0], 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      #2;
      rst = 1'b0;
      #1;
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_rw", {62'd0, mif.mem_read, mif.mem_write}, 64'd0);
      chk("rstmid_ovf", 64'(overflow), 64'd0);
      repeat (3) tick();
      rst = 1'b1;
      repeat (25) tick();
      chk("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
      chk("rstmid_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      run_check("after_reset", vt[4], 0);

      // start held high: ignored in DONE, retriggers in the following IDLE cycle.
      d0 = done_cnt;
      load_vec(vt[1], 4);
      load_vec(vt[1], 4);
      start = 1'b1;
      tick();
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         mon();
         busyv[c] = busy;
         donev[c] = done;
         @(posedge clk);
         #1;
         if (c == 22) start = 1'b0;
      end
      chk("hold_done1", 64'(donev[21]), 64'd1);
      chk("hold_idle_gap", 64'(busyv[22]), 64'd0);
      chk("hold_retrigger", 64'(busyv[23]), 64'd1);
      chk("hold_done2", 64'(donev[43]), 64'd1);
      chk("hold_done_count", 64'(done_cnt - d0), 64'd2);
      chk("hold_pending", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter N, default 2: matrix dimension; A, B and C are all N x N.
REQ-002 Parameter SIZE, default 8: element width in bits; all elements are unsigned.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: request one multiplication; sampled only in IDLE.
REQ-006 Port abort, input, 1: synchronous cancel of the operation in progress.
REQ-007 Port base_a / base_b / base_c, input, 32 each: row-major base addresses of A, B and C.
REQ-008 Port mem_read, output, 1: memory read enable.
REQ-009 Port mem_raddr, output, 32: memory read address.
REQ-010 Port mem_rdata, input, SIZE: read data, valid combinationally in the same cycle as mem_raddr.
REQ-011 Port mem_write, output, 1: memory write enable; the memory commits the write on the clk edge.
REQ-012 Port mem_waddr, output, 32: memory write address.
REQ-013 Port mem_wdata, output, SIZE: memory write data.
REQ-014 Port busy, output, 1: an operation is in progress.
REQ-015 Port done, output, 1: one-cycle completion pulse.
REQ-016 Port overflow, output, 1: sticky flag set when any result element did not fit in SIZE bits.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_A, RD_B, WR and DONE, with loop indices i, j and k, each 0..N-1.
REQ-018 In IDLE with start=1, the block SHALL latch base_a/b/c, clear i, j, k, the accumulator and overflow, and go to RD_A.
REQ-019 In RD_A the block SHALL drive mem_read=1 and mem_raddr=base_a+i*N+k, capture mem_rdata into a_reg, and go to RD_B.
REQ-020 In RD_B the block SHALL drive mem_read=1 and mem_raddr=base_b+k*N+j, and add a_reg*mem_rdata to the accumulator.
- If k<N-1 the block SHALL increment k and go to RD_A; otherwise it SHALL go to WR.
REQ-021 The accumulator SHALL be 2*SIZE+clog2(N) bits wide and SHALL never wrap.
REQ-022 In WR the block SHALL drive mem_write=1, mem_waddr=base_c+i*N+j and mem_wdata=accumulator[SIZE-1:0].
- Overflow SHALL be set if any accumulator bit above SIZE-1 is 1.
- The block SHALL clear the accumulator and k.
REQ-023 On leaving WR, j SHALL advance first and then i (row-major order).
- After element (N-1, N-1) the block SHALL go to DONE; otherwise it SHALL go to RD_A.
REQ-024 In DONE the block SHALL drive done=1 for exactly one cycle, then go to IDLE.
REQ-025 busy SHALL be 1 in RD_A, RD_B and WR, and 0 in IDLE and DONE.
REQ-026 Latency SHALL be N*N*(2N+1) busy cycles, then one done cycle; for N=2 that is 20 busy cycles, with done in cycle 21 after acceptance.
REQ-027 start SHALL be ignored outside IDLE.
- A start asserted in the DONE cycle SHALL be ignored.
- A start held high SHALL retrigger on the cycle after DONE.
REQ-028 abort=1 in RD_A, RD_B or WR SHALL force IDLE at the next edge.
- If abort is high in WR, mem_write SHALL still be 0 in that cycle, so no write occurs.
- An aborted operation SHALL produce no done pulse; overflow SHALL hold its current value.
- abort SHALL have no effect in IDLE and DONE, and SHALL take priority over start.
REQ-029 mem_read and mem_write SHALL never both be 1, and SHALL both be 0 in IDLE and DONE.
- mem_raddr, mem_waddr and mem_wdata SHALL be 0 when their enable is 0.
REQ-030 Address arithmetic SHALL be modulo 2^32 (wrap-around permitted).

Reset
REQ-031 rst=0 SHALL immediately force IDLE from any state, including mid-operation.
- rst=0 SHALL clear i, j, k, a_reg, the accumulator and the latched base addresses.
- Outputs SHALL reset to: busy=0, done=0, overflow=0, mem_read=0, mem_write=0, and all address and data outputs 0.
REQ-032 After rst returns to 1, the first start SHALL be accepted on the next edge at which it is high.

Verification
REQ-033 Basic multiply: N=2, bases 0/4/8, A=[1,2;3,4], B=[5,6;7,8], one-cycle start.
- Writes SHALL be addr 8=19, 9=22, 10=43, 11=50, in that order.
- busy SHALL be high for 20 cycles, done SHALL pulse in cycle 21, and overflow SHALL be 0.
REQ-034 Overflow: A and B all 200 -> every written value SHALL be 128 (80000 mod 256), and overflow SHALL be 1 until the next start.
REQ-035 Start while busy: start pulsed in cycle 5 of a run -> no effect; exactly 4 writes and one done pulse.
REQ-036 Abort: abort asserted in the second WR cycle -> exactly 1 write (addr 8), busy low on the next cycle, no done pulse.
- A following start SHALL then run the full 20-cycle sequence.
REQ-037 Reset mid-operation: rst=0 in cycle 7 -> busy, mem_read and mem_write go to 0 immediately, with no further writes.
- A following start SHALL produce the correct C.
REQ-038 Identity with wrapped base: A=I, B=[9,8;7,6], base_c=32'hFFFFFFFE.
- Writes SHALL go to FFFFFFFE, FFFFFFFF, 0 and 1 with values 9, 8, 7, 6.
